// File: rtl/cpu_wb_bridge.sv
// cpu_wb_bridge: 68040-style CPU bus (sampled on bus_ce) to Wishbone master bridge.
// Single transfers and wrapped line bursts; slave errors, timeouts and bad TT end in TEA.
module cpu_wb_bridge #(
  parameter int LINE_BEATS = 4,
  parameter int TIMEOUT    = 255,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_ce,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_dat_o,
  output logic [31:0]       cpu_dat_i,
  output logic              cpu_dat_oe,
  input  logic [1:0]        cpu_siz,
  input  logic [1:0]        cpu_tt,
  input  logic              cpu_ts_n,
  input  logic              cpu_rw,
  output logic              cpu_ta_n,
  output logic              cpu_tea_n,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [3:0]        wb_sel_o,
  output logic [ADDR_W-3:0] wb_adr_o,
  output logic [31:0]       wb_dat_o,
  input  logic [31:0]       wb_dat_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i
);

  localparam int K  = $clog2(LINE_BEATS);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int BW = $clog2(LINE_BEATS + 1);
  localparam logic [TW-1:0] TLAST      = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [BW-1:0] BEATS_LINE = BW'(LINE_BEATS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_TERM = 2'd3
  } state_t;

  // Big-endian byte lanes: byte 0 of a long word sits on sel[3].
  function automatic logic [3:0] byte_sel(input logic [1:0] siz, input logic [1:0] tt,
                                          input logic [1:0] a);
    logic [3:0] s;
    s = 4'b1111;
    if (tt == 2'b01) begin
      s = 4'b1111;
    end else begin
      case (siz)
        2'b01: begin
          case (a)
            2'b00:   s = 4'b1000;
            2'b01:   s = 4'b0100;
            2'b10:   s = 4'b0010;
            default: s = 4'b0001;
          endcase
        end
        2'b10:   s = a[1] ? 4'b0011 : 4'b1100;
        default: s = 4'b1111;
      endcase
    end
    return s;
  endfunction

  state_t            r_state, w_state;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic              r_rw, w_rw;
  logic [BW-1:0]     r_beats, w_beats;
  logic              r_err, w_err;
  logic              r_hold, w_hold;
  logic [TW-1:0]     r_timer, w_timer;
  logic              r_cyc, w_cyc;
  logic              r_stb, w_stb;
  logic              r_we, w_we;
  logic [3:0]        r_sel, w_sel;
  logic [31:0]       r_wdat, w_wdat;
  logic [31:0]       r_rdat, w_rdat;
  logic              r_ta_n, w_ta_n;
  logic              r_tea_n, w_tea_n;
  logic              r_oe, w_oe;
  logic              w_tmo;

  assign w_tmo = (TIMEOUT != 0) && (r_timer == TLAST);

  // Next-state and next-output logic for the transfer sequencer.
  always_comb begin
    w_state = r_state;
    w_addr  = r_addr;
    w_rw    = r_rw;
    w_beats = r_beats;
    w_err   = r_err;
    w_hold  = r_hold;
    w_timer = r_timer;
    w_cyc   = r_cyc;
    w_stb   = r_stb;
    w_we    = r_we;
    w_sel   = r_sel;
    w_wdat  = r_wdat;
    w_rdat  = r_rdat;
    w_ta_n  = r_ta_n;
    w_tea_n = r_tea_n;
    w_oe    = r_oe;
    case (r_state)
      S_IDLE: begin
        if (bus_ce && !cpu_ts_n) begin
          w_addr  = cpu_addr;
          w_rw    = cpu_rw;
          w_sel   = byte_sel(cpu_siz, cpu_tt, cpu_addr[1:0]);
          w_beats = ((cpu_siz == 2'b11) || (cpu_tt == 2'b01)) ? BEATS_LINE : BW'(1);
          w_hold  = 1'b0;
          if (cpu_tt[1]) begin
            w_err   = 1'b1;
            w_state = S_TERM;
          end else begin
            w_err   = 1'b0;
            w_state = S_REQ;
          end
        end else begin
          w_state = S_IDLE;
        end
      end
      S_REQ: begin
        if (r_rw || bus_ce) begin
          if (!r_rw) begin
            w_wdat = cpu_dat_o;
          end else begin
            w_wdat = r_wdat;
          end
          w_cyc   = 1'b1;
          w_stb   = 1'b1;
          w_we    = !r_rw;
          w_timer = {TW{1'b0}};
          w_state = S_WAIT;
        end else begin
          w_state = S_REQ;
        end
      end
      S_WAIT: begin
        w_timer = (&r_timer) ? r_timer : r_timer + TW'(1);
        // Slave error beats ack, and any slave response beats the timeout.
        if (wb_err_i || (!wb_ack_i && w_tmo)) begin
          w_stb   = 1'b0;
          w_cyc   = 1'b0;
          w_we    = 1'b0;
          w_err   = 1'b1;
          w_hold  = 1'b0;
          w_state = S_TERM;
        end else if (wb_ack_i) begin
          w_stb = 1'b0;
          if (r_rw) begin
            w_rdat = wb_dat_i;
          end else begin
            w_rdat = r_rdat;
          end
          w_cyc   = (r_beats > BW'(1));
          w_we    = w_cyc ? r_we : 1'b0;
          w_hold  = 1'b0;
          w_state = S_TERM;
        end else begin
          w_state = S_WAIT;
        end
      end
      S_TERM: begin
        if (bus_ce) begin
          if (!r_hold) begin
            w_hold  = 1'b1;
            w_ta_n  = r_err;
            w_tea_n = !r_err;
            w_oe    = r_rw;
          end else begin
            w_hold  = 1'b0;
            w_ta_n  = 1'b1;
            w_tea_n = 1'b1;
            w_oe    = 1'b0;
            if (r_err || (r_beats == BW'(1))) begin
              w_cyc   = 1'b0;
              w_stb   = 1'b0;
              w_we    = 1'b0;
              w_state = S_IDLE;
            end else begin
              w_beats       = r_beats - BW'(1);
              w_addr[K+1:2] = r_addr[K+1:2] + K'(1);
              w_state       = S_REQ;
            end
          end
        end else begin
          w_state = S_TERM;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transfer without TA/TEA.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= {ADDR_W{1'b0}};
      r_rw    <= 1'b0;
      r_beats <= {BW{1'b0}};
      r_err   <= 1'b0;
      r_hold  <= 1'b0;
      r_timer <= {TW{1'b0}};
      r_cyc   <= 1'b0;
      r_stb   <= 1'b0;
      r_we    <= 1'b0;
      r_sel   <= 4'b0000;
      r_wdat  <= 32'h0000_0000;
      r_rdat  <= 32'h0000_0000;
      r_ta_n  <= 1'b1;
      r_tea_n <= 1'b1;
      r_oe    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_addr  <= w_addr;
      r_rw    <= w_rw;
      r_beats <= w_beats;
      r_err   <= w_err;
      r_hold  <= w_hold;
      r_timer <= w_timer;
      r_cyc   <= w_cyc;
      r_stb   <= w_stb;
      r_we    <= w_we;
      r_sel   <= w_sel;
      r_wdat  <= w_wdat;
      r_rdat  <= w_rdat;
      r_ta_n  <= w_ta_n;
      r_tea_n <= w_tea_n;
      r_oe    <= w_oe;
    end
  end

  assign cpu_dat_i  = r_rdat;
  assign cpu_dat_oe = r_oe;
  assign cpu_ta_n   = r_ta_n;
  assign cpu_tea_n  = r_tea_n;
  assign wb_cyc_o   = r_cyc;
  assign wb_stb_o   = r_stb;
  assign wb_we_o    = r_we;
  assign wb_sel_o   = r_sel;
  assign wb_adr_o   = r_addr[ADDR_W-1:2];
  assign wb_dat_o   = r_wdat;

endmodule
